combo_lock_ctrl: RTL and testbench

Sequencing controller for the Basys combination lock. It consumes single-cycle button pulses from the board top level, edits and latches four hex code digits, and compares them against the stored code. It drives unlock, fail and lockout status to the LEDs and provides entered digits to the seven-segment driver. It sits between the button edge-detect logic and the display/LED outputs in `basys`.

---
 rtl/combo_lock_pkg.sv | 29 ++
 rtl/combo_timer.sv | 28 ++
 rtl/combo_lock_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_combo_lock_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// Shared types and sizing for the combination-lock controller.
// Optional program mode is enabled by defining COMBO_LOCK_PROG_EN.
package combo_lock_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Controller states; PROG exists only when code programming is built in.
    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_FAIL    = 3'd3,
`ifdef COMBO_LOCK_PROG_EN
        ST_LOCKOUT = 3'd4,
        ST_PROG    = 3'd5
`else
        ST_LOCKOUT = 3'd4
`endif
    } state_t;

    // Bits needed to hold a cycle count of n.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/combo_timer.sv
// Loadable down-counter used to time the FAIL and LOCKOUT holds.
// Loading len gives done high exactly len cycles after the load edge.
module combo_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_len,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Count down to zero and rest there until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_len - W'(1);
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: digit editing, code check, fail/lockout hold.
// Define COMBO_LOCK_PROG_EN to add a PROG state and a programmable code register.
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter logic [15:0] CODE           = 16'hFACE,
    parameter int          MAX_FAIL       = 3,
    parameter int          FAIL_CYCLES    = 8,
    parameter int          LOCKOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    input  logic                enter,
    input  logic                clear,
    input  logic                prog,
    output logic [DIGIT_W-1:0]  cur_digit,
    output logic [IDX_W-1:0]    digit_idx,
    output logic [CODE_W-1:0]   entered,
    output logic                unlocked,
    output logic                fail,
    output logic                locked_out,
    output logic [3:0]          fail_cnt
);

    localparam int MAX_HOLD = (LOCKOUT_CYCLES > FAIL_CYCLES) ? LOCKOUT_CYCLES : FAIL_CYCLES;
    localparam int TW       = count_w(MAX_HOLD);

    state_t              r_state;
    logic [DIGIT_W-1:0]  r_cur_digit;
    logic [IDX_W-1:0]    r_digit_idx;
    logic [CODE_W-1:0]   r_entered;
    logic                r_unlocked;
    logic                r_fail;
    logic                r_locked_out;
    logic [3:0]          r_fail_cnt;

    logic [DIGIT_W-1:0]  w_cur_adj;
    logic [CODE_W-1:0]   w_entered_wr;
    logic [CODE_W-1:0]   w_code;
    logic [3:0]          w_fail_next;
    logic                w_match;
    logic                w_last_digit;
    logic                w_timer_load;
    logic [TW-1:0]       w_timer_len;
    logic                w_timer_done;

`ifdef COMBO_LOCK_PROG_EN
    logic [CODE_W-1:0]   r_code;
    assign w_code = r_code;
`else
    logic                w_unused_prog;
    assign w_unused_prog = prog;
    assign w_code        = CODE;
`endif

    // Entered value with the current digit dropped into the edited position.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_wr
            localparam int HI = CODE_W - 1 - gi * DIGIT_W;
            assign w_entered_wr[HI -: DIGIT_W] = (r_digit_idx == IDX_W'(gi)) ?
                                                 r_cur_digit : r_entered[HI -: DIGIT_W];
        end
    endgenerate

    // Digit edit: inc and dec together cancel out; wraps mod 16.
    always_comb begin
        w_cur_adj = r_cur_digit;
        if (inc && !dec) begin
            w_cur_adj = r_cur_digit + DIGIT_W'(1);
        end else if (dec && !inc) begin
            w_cur_adj = r_cur_digit - DIGIT_W'(1);
        end
    end

    assign w_last_digit = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_match      = (r_entered == w_code);
    assign w_fail_next  = r_fail_cnt + 4'd1;

    // The hold timer is loaded on the CHECK cycle of a wrong attempt.
    assign w_timer_load = (r_state == ST_CHECK) && !w_match;
    assign w_timer_len  = (w_fail_next == 4'(MAX_FAIL)) ? TW'(LOCKOUT_CYCLES) : TW'(FAIL_CYCLES);

    combo_timer #(
        .W      (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_timer_load),
        .i_len  (w_timer_len),
        .o_done (w_timer_done)
    );

    // Main sequencer; status flags are set on the same edge as the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ENTRY;
            r_cur_digit  <= '0;
            r_digit_idx  <= '0;
            r_entered    <= '0;
            r_unlocked   <= 1'b0;
            r_fail       <= 1'b0;
            r_locked_out <= 1'b0;
            r_fail_cnt   <= '0;
`ifdef COMBO_LOCK_PROG_EN
            r_code       <= CODE;
`endif
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (clear) begin
                        r_cur_digit <= '0;
                        r_digit_idx <= '0;
                        r_entered   <= '0;
                    end else if (enter) begin
                        r_entered   <= w_entered_wr;
                        r_digit_idx <= r_digit_idx + IDX_W'(1);
                        if (w_last_digit) begin
                            r_state <= ST_CHECK;
                        end
                    end else begin
                        r_cur_digit <= w_cur_adj;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_state    <= ST_OPEN;
                        r_unlocked <= 1'b1;
                        r_fail_cnt <= '0;
                    end else begin
                        r_fail_cnt <= w_fail_next;
                        if (w_fail_next == 4'(MAX_FAIL)) begin
                            r_state      <= ST_LOCKOUT;
                            r_locked_out <= 1'b1;
                        end else begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end
                end
                ST_OPEN: begin
                    if (clear) begin
                        r_state     <= ST_ENTRY;
                        r_unlocked  <= 1'b0;
                        r_cur_digit <= '0;
                        r_digit_idx <= '0;
                        r_entered   <= '0;
`ifdef COMBO_LOCK_PROG_EN
                    end else if (enter && prog) begin
                        r_state     <= ST_PROG;
                        r_unlocked  <= 1'b0;
                        r_cur_digit <= '0;
                        r_digit_idx <= '0;
                        r_entered   <= '0;
`endif
                    end
                end
                ST_FAIL: begin
                    if (w_timer_done) begin
                        r_state     <= ST_ENTRY;
                        r_fail      <= 1'b0;
                        r_cur_digit <= '0;
                        r_digit_idx <= '0;
                        r_entered   <= '0;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_timer_done) begin
                        r_state      <= ST_ENTRY;
                        r_locked_out <= 1'b0;
                        r_fail_cnt   <= '0;
                        r_cur_digit  <= '0;
                        r_digit_idx  <= '0;
                        r_entered    <= '0;
                    end
                end
`ifdef COMBO_LOCK_PROG_EN
                ST_PROG: begin
                    if (clear) begin
                        r_state     <= ST_OPEN;
                        r_unlocked  <= 1'b1;
                        r_cur_digit <= '0;
                        r_digit_idx <= '0;
                        r_entered   <= '0;
                    end else if (enter) begin
                        r_entered   <= w_entered_wr;
                        r_digit_idx <= r_digit_idx + IDX_W'(1);
                        if (w_last_digit) begin
                            r_code      <= w_entered_wr;
                            r_state     <= ST_OPEN;
                            r_unlocked  <= 1'b1;
                            r_cur_digit <= '0;
                            r_digit_idx <= '0;
                            r_entered   <= '0;
                        end
                    end else begin
                        r_cur_digit <= w_cur_adj;
                    end
                end
`endif
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    assign cur_digit  = r_cur_digit;
    assign digit_idx  = r_digit_idx;
    assign entered    = r_entered;
    assign unlocked   = r_unlocked;
    assign fail       = r_fail;
    assign locked_out = r_locked_out;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl: directed scenarios then random pulses,
// every cycle compared against a behavioural model. Honours COMBO_LOCK_PROG_EN.
module tb_combo_lock_ctrl;

    localparam logic [15:0] CODE           = 16'hFACE;
    localparam int          MAX_FAIL       = 3;
    localparam int          FAIL_CYCLES    = 8;
    localparam int          LOCKOUT_CYCLES = 64;
`ifdef COMBO_LOCK_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        inc;
    logic        dec;
    logic        enter;
    logic        clear;
    logic        prog;
    logic [3:0]  cur_digit;
    logic [1:0]  digit_idx;
    logic [15:0] entered;
    logic        unlocked;
    logic        fail;
    logic        locked_out;
    logic [3:0]  fail_cnt;

    combo_lock_ctrl #(
        .CODE           (CODE),
        .MAX_FAIL       (MAX_FAIL),
        .FAIL_CYCLES    (FAIL_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .dec        (dec),
        .enter      (enter),
        .clear      (clear),
        .prog       (prog),
        .cur_digit  (cur_digit),
        .digit_idx  (digit_idx),
        .entered    (entered),
        .unlocked   (unlocked),
        .fail       (fail),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4, M_PROG = 5;
    int          m_mode;
    int          m_cur;
    int          m_idx;
    logic [15:0] m_entered;
    int          m_fails;
    int          m_hold;
    logic [15:0] m_code;

    task automatic model_zero_entry();
        m_cur = 0; m_idx = 0; m_entered = '0;
    endtask

    task automatic model_reset();
        m_mode = M_ENTRY; m_fails = 0; m_hold = 0; m_code = CODE;
        model_zero_entry();
    endtask

    task automatic model_step(input bit a_inc, input bit a_dec, input bit a_enter,
                              input bit a_clear, input bit a_prog, input bit a_rst);
        if (a_rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_ENTRY, M_PROG: begin
                if (a_clear) begin
                    model_zero_entry();
                    if (m_mode == M_PROG) m_mode = M_OPEN;
                end else if (a_enter) begin
                    m_entered[15 - 4*m_idx -: 4] = 4'(m_cur);
                    if (m_idx == 3) begin
                        m_idx = 0;
                        if (m_mode == M_ENTRY) begin
                            m_mode = M_CHECK;
                        end else begin
                            m_code = m_entered;
                            model_zero_entry();
                            m_mode = M_OPEN;
                        end
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end else if (a_inc && !a_dec) begin
                    m_cur = (m_cur + 1) % 16;
                end else if (a_dec && !a_inc) begin
                    m_cur = (m_cur + 15) % 16;
                end
            end
            M_CHECK: begin
                if (m_entered == m_code) begin
                    m_mode = M_OPEN; m_fails = 0;
                end else begin
                    m_fails = m_fails + 1;
                    if (m_fails == MAX_FAIL) begin m_mode = M_LOCK; m_hold = LOCKOUT_CYCLES; end
                    else                     begin m_mode = M_FAIL; m_hold = FAIL_CYCLES;    end
                end
            end
            M_OPEN: begin
                if (a_clear) begin
                    m_mode = M_ENTRY; model_zero_entry();
                end else if (PROG_EN && a_prog && a_enter) begin
                    m_mode = M_PROG; model_zero_entry();
                end
            end
            M_FAIL: begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin m_mode = M_ENTRY; model_zero_entry(); end
            end
            M_LOCK: begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin m_mode = M_ENTRY; m_fails = 0; model_zero_entry(); end
            end
            default: m_mode = M_ENTRY;
        endcase
    endtask

    task automatic compare_all();
        check_val("cur_digit",  32'(cur_digit),  32'(m_cur));
        check_val("digit_idx",  32'(digit_idx),  32'(m_idx));
        check_val("entered",    32'(entered),    32'(m_entered));
        check_val("unlocked",   32'(unlocked),   32'(m_mode == M_OPEN));
        check_val("fail",       32'(fail),       32'(m_mode == M_FAIL));
        check_val("locked_out", 32'(locked_out), 32'(m_mode == M_LOCK));
        check_val("fail_cnt",   32'(fail_cnt),   32'(m_fails));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_cycle(input bit a_inc, input bit a_dec, input bit a_enter,
                            input bit a_clear, input bit a_prog, input bit a_rst);
        inc = a_inc; dec = a_dec; enter = a_enter; clear = a_clear; prog = a_prog; rst = a_rst;
        @(posedge clk);
        cyc++;
        model_step(a_inc, a_dec, a_enter, a_clear, a_prog, a_rst);
        #1;
        inc = 1'b0; dec = 1'b0; enter = 1'b0; clear = 1'b0; prog = 1'b0; rst = 1'b0;
        if (a_enter || a_clear || a_rst)
            $display("txn cycle=%0d inc=%0b dec=%0b enter=%0b clear=%0b prog=%0b rst=%0b -> entered=%h idx=%0d cnt=%0d",
                     cyc, a_inc, a_dec, a_enter, a_clear, a_prog, a_rst, entered, digit_idx, fail_cnt);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Walk the current digit up to each target value, then confirm it.
    task automatic enter_code(input logic [15:0] code);
        logic [15:0] c;
        int steps;
        c = code;
        for (int i = 0; i < 4; i++) begin
            steps = (int'(c[15 - 4*i -: 4]) - m_cur + 16) % 16;
            for (int s = 0; s < steps; s++) do_cycle(1, 0, 0, 0, 0, 0);
            do_cycle(0, 0, 1, 0, 0, 0);
        end
    endtask

    // Bounded wait for the model to be back in ENTRY.
    task automatic wait_entry();
        int n;
        n = 0;
        while (m_mode != M_ENTRY && n < 200) begin
            do_cycle(0, 0, 0, 0, 0, 0);
            n++;
        end
        check_val("wait_entry_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    int cnt;
    int r;

    initial begin
        inc = 0; dec = 0; enter = 0; clear = 0; prog = 0; rst = 1;
        model_reset();
        do_cycle(0, 0, 0, 0, 0, 1);
        do_cycle(0, 0, 0, 0, 0, 1);
        check_val("reset_entered", 32'(entered), 32'h0);

        // Official code via L, C, L x5, C, R x2, C, R x2, C.
        do_cycle(0, 1, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0, 0);
        check_val("prog_F000", 32'(entered), 32'hF000);
        for (int i = 0; i < 5; i++) do_cycle(0, 1, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0, 0);
        check_val("prog_FA00", 32'(entered), 32'hFA00);
        do_cycle(1, 0, 0, 0, 0, 0); do_cycle(1, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0, 0);
        check_val("prog_FAC0", 32'(entered), 32'hFAC0);
        do_cycle(1, 0, 0, 0, 0, 0); do_cycle(1, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0, 0);
        check_val("prog_FACE", 32'(entered), 32'hFACE);
        check_val("unlock_not_yet", 32'(unlocked), 32'd0);
        idle(1);
        check_val("unlock_after_2", 32'(unlocked), 32'd1);
        check_val("unlock_cnt0", 32'(fail_cnt), 32'd0);
        idle(3);
        do_cycle(0, 0, 0, 1, 0, 0);
        check_val("relock_unlocked", 32'(unlocked), 32'd0);

        // Three wrong attempts: two FAIL holds then LOCKOUT ignoring clear.
        for (int a = 0; a < 3; a++) begin
            enter_code(16'h1234);
            cnt = 0;
            for (int i = 0; i < 75; i++) begin
                do_cycle(0, 0, 0, (i % 5) == 3, 0, 0);
                if (a < 2 && fail) cnt++;
                if (a == 2 && locked_out) cnt++;
                if (a < 2 && i == 12) break;
            end
            if (a < 2) begin
                check_val("fail_hold_cycles", 32'(cnt), 32'(FAIL_CYCLES));
                check_val("fail_cnt_step", 32'(fail_cnt), 32'(a + 1));
            end else begin
                check_val("lockout_cycles", 32'(cnt), 32'(LOCKOUT_CYCLES));
                check_val("lockout_cnt0", 32'(fail_cnt), 32'd0);
            end
        end

        // Corner cases: inc+dec, enter+clear, wrap both ways.
        do_cycle(1, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 0, 0, 0, 0);
        check_val("inc_dec_cancel", 32'(cur_digit), 32'd1);
        do_cycle(0, 0, 1, 0, 0, 0);
        do_cycle(0, 0, 1, 1, 0, 0);
        check_val("enter_clear", 32'(entered), 32'h0);
        do_cycle(0, 1, 0, 0, 0, 0);
        check_val("dec_wrap", 32'(cur_digit), 32'hF);
        do_cycle(1, 0, 0, 0, 0, 0);
        check_val("inc_wrap", 32'(cur_digit), 32'h0);

        // Reset mid-entry and mid-lockout.
        do_cycle(0, 1, 0, 0, 0, 0); do_cycle(0, 0, 1, 0, 0, 0); do_cycle(0, 0, 1, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 1);
        check_val("rst_mid_entry", 32'(entered), 32'h0);
        for (int a = 0; a < 3; a++) begin
            enter_code(16'h0BAD);
            idle(3);
            if (a < 2) wait_entry();
        end
        check_val("in_lockout", 32'(locked_out), 32'd1);
        do_cycle(0, 0, 0, 0, 0, 1);
        check_val("rst_lockout", 32'(locked_out), 32'd0);
        check_val("rst_lockout_cnt", 32'(fail_cnt), 32'd0);

`ifdef COMBO_LOCK_PROG_EN
        enter_code(CODE);
        idle(1);
        do_cycle(0, 0, 1, 0, 1, 0);
        enter_code(16'h0001);
        check_val("prog_back_open", 32'(unlocked), 32'd1);
        do_cycle(0, 0, 0, 1, 0, 0);
        enter_code(CODE);
        idle(1);
        check_val("old_code_fails", 32'(fail), 32'd1);
        wait_entry();
        enter_code(16'h0001);
        idle(1);
        check_val("new_code_opens", 32'(unlocked), 32'd1);
        do_cycle(0, 0, 0, 1, 0, 0);
`endif

        // Random pulses, with periodic correct-code entries to reach OPEN.
        for (int n = 0; n < 3000; n++) begin
            if ((n % 250) == 0) begin
                wait_entry();
                do_cycle(0, 0, 0, 1, 0, 0);
                enter_code(m_code);
            end
            r = int'($urandom_range(0, 99));
            if      (r < 28) do_cycle(1, 0, 0, 0, 0, 0);
            else if (r < 52) do_cycle(0, 1, 0, 0, 0, 0);
            else if (r < 58) do_cycle(1, 1, 0, 0, 0, 0);
            else if (r < 70) do_cycle(0, 0, 1, 0, $urandom_range(0, 1) == 1, 0);
            else if (r < 74) do_cycle(0, 0, 0, 1, 0, 0);
            else if (r < 76) do_cycle(0, 0, 1, 1, 0, 0);
            else if (r < 77) do_cycle(0, 0, 0, 0, 0, 1);
            else             do_cycle(0, 0, 0, 0, $urandom_range(0, 1) == 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
